// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: width, opcodes, FSM states and
// the single-cycle operation helper used by the EXEC path.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  // Returns {carry, result}. Opcode 111 is a pass-through of A here; the
  // real product comes from the sequential multiplier when it is built.
  function automatic logic [WIDTH:0] alu_calc(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] res;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_SHL:  res = {a, 1'b0};
      OP_SHR:  res = {a[0], 1'b0, a[WIDTH-1:1]};
      default: res = {1'b0, a};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_stage_if.sv
// Operand, control and result signals of the ALU stage.
// Handshake: start is accepted only when busy=0; done pulses for one cycle
// when R and the flags have just been updated. start while busy is dropped.
interface alu_stage_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] Acc_in;
  logic [WIDTH-1:0] Bus_in;
  logic             WE_B;
  logic [2:0]       op;
  logic             start;
  logic             OE;
  logic [WIDTH-1:0] Alu_out;
  logic             Z;
  logic             C;
  logic             N;
  logic             busy;
  logic             done;

  modport master (
    output Acc_in, Bus_in, WE_B, op, start, OE,
    input  Alu_out, Z, C, N, busy, done
  );

  modport slave (
    input  Acc_in, Bus_in, WE_B, op, start, OE,
    output Alu_out, Z, C, N, busy, done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative 8x8 shift-add multiplier: load captures the operands, each step
// consumes one multiplier bit; the product is complete after 8 steps.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (load) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (step) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// ALU stage behind the accumulator: B register, 8 operations, Z/C/N flags
// and an OE-gated bus output. Define ALU_MUL_EN to build the multiplier.
module alu_stage
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  alu_stage_if.slave  bus,
  output alu_state_e  state_dbg
);

  alu_state_e       state, next_state;
  logic [WIDTH-1:0] b_reg, a_q, b_q, r_q, alu_out_q;
  logic [2:0]       op_q;
  logic             z_q, c_q, n_q;
  logic             capture, write_r, busy, done;
  logic [WIDTH:0]   exec_res;
  logic [WIDTH-1:0] r_new;
  logic             c_new;

`ifdef ALU_MUL_EN
  logic               mul_load, mul_step;
  logic [3:0]         cnt;
  logic [2*WIDTH-1:0] product;

  alu_mul_seq u_mul (
    .clk     (CLK),
    .rst     (RESET),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.Acc_in),
    .b       (b_reg),
    .product (product)
  );

  // Nine cycles in MUL: eight multiply steps, then the write-back cycle.
  always_ff @(posedge CLK) begin
    if (RESET)         cnt <= '0;
    else if (mul_load) cnt <= '0;
    else if (mul_step) cnt <= cnt + 4'd1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    write_r    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
`ifdef ALU_MUL_EN
    mul_load   = 1'b0;
    mul_step   = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        done       = (state == DONE);
        next_state = IDLE;
        if (bus.start) begin
          capture = 1'b1;
`ifdef ALU_MUL_EN
          if (bus.op == OP_MUL) begin
            next_state = MUL;
            mul_load   = 1'b1;
          end else begin
            next_state = EXEC;
          end
`else
          next_state = EXEC;
`endif
        end
      end
      EXEC: begin
        busy       = 1'b1;
        write_r    = 1'b1;
        next_state = DONE;
      end
      MUL: begin
        busy = 1'b1;
`ifdef ALU_MUL_EN
        if (cnt == 4'd8) begin
          write_r    = 1'b1;
          next_state = DONE;
        end else begin
          mul_step = 1'b1;
        end
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    exec_res = alu_calc(op_q, a_q, b_q);
    r_new    = exec_res[WIDTH-1:0];
    c_new    = exec_res[WIDTH];
`ifdef ALU_MUL_EN
    if (state == MUL) begin
      r_new = product[WIDTH-1:0];
      c_new = |product[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // B loads independently of the FSM; the running op works on its own copy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      b_reg     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      r_q       <= '0;
      alu_out_q <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      if (bus.WE_B) b_reg <= bus.Bus_in;
      if (capture) begin
        a_q  <= bus.Acc_in;
        b_q  <= b_reg;
        op_q <= bus.op;
      end
      if (bus.OE) alu_out_q <= r_q;
      if (write_r) begin
        r_q <= r_new;
        c_q <= c_new;
        z_q <= (r_new == '0);
        n_q <= r_new[WIDTH-1];
      end
    end
  end

  assign bus.Alu_out = alu_out_q;
  assign bus.Z       = z_q;
  assign bus.C       = c_q;
  assign bus.N       = n_q;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign state_dbg   = state;

endmodule
